j1_loader: RTL and testbench

J1_LOADER -- requirements
Module: j1_loader

---
 rtl/j1_pkg.sv | 19 +
 rtl/j1_loader.sv | 157 +++++++++++++++
 tb/tb_j1_loader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/j1_pkg.sv
// Shared definitions for the J1 program loader: state encoding, frame marker
// and checksum width.
package j1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT_LO,
        CNT_HI,
        DAT_LO,
        DAT_HI,
        WRITE,
        CSUM,
        RUN
    } j1_state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         CSUM_W        = 8;

endpackage

// File: rtl/j1_loader.sv
// Byte-stream boot loader: receives a framed program image, writes it into
// J1 program memory and holds the core in reset until a good image is loaded.
module j1_loader
    import j1_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         MAX_WORDS = 8192,
    parameter int         TIMEOUT   = 100000
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        reload_i,
    output logic        cpu_rst_o,
    output logic [15:0] pgm_addr,
    output logic [15:0] pgm_data,
    output logic        pgm_we,
    output logic        load_done,
    output logic        load_err
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    j1_state_e           state_reg, state_next;
    logic [15:0]         count_reg;
    logic [15:0]         index_reg;
    logic [CSUM_W-1:0]   csum_reg;
    logic [7:0]          lo_reg;
    logic [TMR_W-1:0]    timer_reg;
    logic                rx_ready_reg, cpu_rst_reg, load_done_reg, load_err_reg, pgm_we_reg;
    logic [15:0]         pgm_addr_reg, pgm_data_reg;

    logic                accept;
    logic                waiting;
    logic                timeout_hit;
    logic                err_set, err_clr;
    logic [15:0]         cnt_word;

    assign accept      = rx_valid & rx_ready_reg;
    assign waiting     = state_reg inside {CNT_LO, CNT_HI, DAT_LO, DAT_HI, CSUM};
    assign timeout_hit = waiting && !accept && (timer_reg == TMR_W'(TIMEOUT - 1));
    assign cnt_word    = {rx_data, count_reg[7:0]};

    always_comb begin
        state_next = state_reg;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    state_next = CNT_LO;
                    err_clr    = 1'b1;
                end
            end
            CNT_LO: if (accept) state_next = CNT_HI;
            CNT_HI: begin
                if (accept) begin
                    if (cnt_word == 16'd0 || {16'd0, cnt_word} > 32'(MAX_WORDS)) begin
                        state_next = IDLE;
                        err_set    = 1'b1;
                    end else begin
                        state_next = DAT_LO;
                    end
                end
            end
            DAT_LO: if (accept) state_next = DAT_HI;
            DAT_HI: if (accept) state_next = WRITE;
            WRITE:  state_next = (index_reg == count_reg - 16'd1) ? CSUM : DAT_LO;
            CSUM: begin
                if (accept) begin
                    if (rx_data == csum_reg) begin
                        state_next = RUN;
                    end else begin
                        state_next = IDLE;
                        err_set    = 1'b1;
                    end
                end
            end
            RUN: if (reload_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // A stalled sender abandons the frame regardless of which byte it owed.
        if (timeout_hit) begin
            state_next = IDLE;
            err_set    = 1'b1;
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            index_reg     <= '0;
            csum_reg      <= '0;
            lo_reg        <= '0;
            timer_reg     <= '0;
            rx_ready_reg  <= 1'b0;
            cpu_rst_reg   <= 1'b1;
            load_done_reg <= 1'b0;
            load_err_reg  <= 1'b0;
            pgm_we_reg    <= 1'b0;
            pgm_addr_reg  <= '0;
            pgm_data_reg  <= '0;
        end else begin
            state_reg <= state_next;

            if (waiting && !accept) timer_reg <= timer_reg + TMR_W'(1);
            else                    timer_reg <= '0;

            case (state_reg)
                CNT_LO: if (accept) count_reg[7:0] <= rx_data;
                CNT_HI: begin
                    if (accept) begin
                        count_reg[15:8] <= rx_data;
                        index_reg       <= '0;
                        csum_reg        <= '0;
                    end
                end
                DAT_LO: begin
                    if (accept) begin
                        lo_reg   <= rx_data;
                        csum_reg <= csum_reg + rx_data;
                    end
                end
                DAT_HI: begin
                    if (accept) begin
                        csum_reg     <= csum_reg + rx_data;
                        pgm_data_reg <= {rx_data, lo_reg};
                        pgm_addr_reg <= {2'b00, index_reg[12:0], 1'b0};
                    end
                end
                WRITE:   index_reg <= index_reg + 16'd1;
                default: ;
            endcase

            // Outputs are registered from the next state so they line up with it.
            rx_ready_reg  <= !(state_next inside {WRITE, RUN});
            cpu_rst_reg   <= (state_next != RUN);
            load_done_reg <= (state_next == RUN);
            pgm_we_reg    <= (state_next == WRITE);

            if (err_set)      load_err_reg <= 1'b1;
            else if (err_clr) load_err_reg <= 1'b0;
        end
    end

    assign rx_ready  = rx_ready_reg;
    assign cpu_rst_o = cpu_rst_reg;
    assign load_done = load_done_reg;
    assign load_err  = load_err_reg;
    assign pgm_we    = pgm_we_reg;
    assign pgm_addr  = pgm_addr_reg;
    assign pgm_data  = pgm_data_reg;

endmodule

// File: tb/tb_j1_loader.sv
// Self-checking bench for j1_loader: directed frames plus randomized frames
// checked against a frame-level reference of expected writes and outcome.
module tb_j1_loader;

    localparam int TIMEOUT   = 50;
    localparam int MAX_WORDS = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        reload_i = 1'b0;
    logic        cpu_rst_o;
    logic [15:0] pgm_addr, pgm_data;
    logic        pgm_we, load_done, load_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         got_q[$];
    logic [15:0] tx_words[$];

    j1_loader #(
        .SYNC_BYTE (8'hA5),
        .MAX_WORDS (MAX_WORDS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .reload_i  (reload_i),
        .cpu_rst_o (cpu_rst_o),
        .pgm_addr  (pgm_addr),
        .pgm_data  (pgm_data),
        .pgm_we    (pgm_we),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Capture every program write; a write must never coincide with rx_ready.
    always @(negedge clk) begin
        if (pgm_we === 1'b1) begin
            got_q.push_back({pgm_addr, pgm_data});
            check_eq("we_while_ready", 32'(rx_ready), 32'd0);
        end
    end

    // Called and returns on a falling edge; waits for rx_ready with a bound.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (rx_ready !== 1'b1) begin
            check_eq("rx_ready_wait", 32'(rx_ready), 32'd1);
            rx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic gap_cycles(input int g);
        repeat (g) @(negedge clk);
    endtask

    task automatic do_reload();
        reload_i = 1'b1;
        @(negedge clk);
        reload_i = 1'b0;
        check_eq("reload_cpu_rst", 32'(cpu_rst_o), 32'd1);
        check_eq("reload_done", 32'(load_done), 32'd0);
        check_eq("reload_ready", 32'(rx_ready), 32'd1);
        $display("[TB] reload pulse: cpu_rst_o=%0b load_done=%0b", cpu_rst_o, load_done);
    endtask

    // Sends one frame carrying tx_words and checks writes and outcome.
    task automatic send_frame(input string name, input int ngarb, input int gap,
                              input bit bad_csum, input bit stray_reload);
        int          n = tx_words.size();
        logic [7:0]  sum = 8'h00;
        logic [7:0]  g;
        bit          ok;
        got_q.delete();
        for (int i = 0; i < ngarb; i++) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h00;
            send_byte(g);
        end
        send_byte(8'hA5);
        check_eq({name, "_err_clr"}, 32'(load_err), 32'd0);
        gap_cycles(gap);
        send_byte(8'(n));
        gap_cycles(gap);
        send_byte(8'(n >> 8));
        if (stray_reload) begin
            reload_i = 1'b1;
            @(negedge clk);
            reload_i = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            gap_cycles(gap);
            send_byte(tx_words[i][7:0]);
            gap_cycles(gap);
            send_byte(tx_words[i][15:8]);
            sum = sum + tx_words[i][7:0] + tx_words[i][15:8];
        end
        gap_cycles(gap);
        send_byte(bad_csum ? sum + 8'd1 : sum);
        ok = !bad_csum;
        check_eq({name, "_done"}, 32'(load_done), 32'(ok));
        check_eq({name, "_cpu_rst"}, 32'(cpu_rst_o), 32'(!ok));
        check_eq({name, "_err"}, 32'(load_err), 32'(!ok));
        check_eq({name, "_nwrites"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            check_eq({name, "_addr"}, 32'(got_q[i].addr), 32'(2 * i));
            check_eq({name, "_data"}, 32'(got_q[i].data), 32'(tx_words[i]));
        end
        check_eq({name, "_addr_hold"}, 32'(pgm_addr), 32'(2 * (n - 1)));
        $display("[TB] frame %s: n=%0d gap=%0d bad_csum=%0b writes=%0d done=%0b err=%0b",
                 name, n, gap, bad_csum, got_q.size(), load_done, load_err);
    endtask

    task automatic bad_count(input string name, input logic [7:0] lo, input logic [7:0] hi);
        got_q.delete();
        send_byte(8'hA5);
        send_byte(lo);
        send_byte(hi);
        gap_cycles(3);
        check_eq({name, "_err"}, 32'(load_err), 32'd1);
        check_eq({name, "_nwrites"}, 32'(got_q.size()), 32'd0);
        check_eq({name, "_cpu_rst"}, 32'(cpu_rst_o), 32'd1);
        check_eq({name, "_ready"}, 32'(rx_ready), 32'd1);
        $display("[TB] count %s: N=0x%02h%02h err=%0b writes=%0d", name, hi, lo, load_err, got_q.size());
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(rx_ready), 32'd0);
        check_eq("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
        check_eq("rst_done", 32'(load_done), 32'd0);
        check_eq("rst_err", 32'(load_err), 32'd0);
        check_eq("rst_we", 32'(pgm_we), 32'd0);
        check_eq("rst_addr", 32'(pgm_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_release_ready", 32'(rx_ready), 32'd1);

        tx_words = '{16'h1234, 16'h5678};
        send_frame("basic", 0, 0, 1'b0, 1'b0);
        do_reload();

        send_frame("badsum", 0, 0, 1'b1, 1'b0);
        check_eq("badsum_no_release", 32'(cpu_rst_o), 32'd1);
        send_byte(8'h00);
        send_byte(8'hFF);
        tx_words = '{16'hA5A5, 16'h00A5, 16'h1234};
        send_frame("garbage_gap10", 0, 10, 1'b0, 1'b1);
        do_reload();

        bad_count("zero", 8'h00, 8'h00);
        bad_count("over", 8'h01, 8'h20);
        tx_words = '{16'hBEEF};
        send_frame("after_bad_count", 1, 0, 1'b0, 1'b0);
        do_reload();

        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        gap_cycles(TIMEOUT - 1);
        check_eq("timeout_early", 32'(load_err), 32'd0);
        gap_cycles(1);
        check_eq("timeout_err", 32'(load_err), 32'd1);
        check_eq("timeout_ready", 32'(rx_ready), 32'd1);
        $display("[TB] timeout stall %0d cycles: err=%0b", TIMEOUT, load_err);

        tx_words = '{16'hCAFE, 16'h0001};
        send_frame("long_gap", 0, TIMEOUT - 5, 1'b0, 1'b0);
        do_reload();

        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        rst = 1'b1;
        #1;
        check_eq("midrst_ready", 32'(rx_ready), 32'd0);
        check_eq("midrst_cpu_rst", 32'(cpu_rst_o), 32'd1);
        check_eq("midrst_we", 32'(pgm_we), 32'd0);
        check_eq("midrst_addr", 32'(pgm_addr), 32'd0);
        check_eq("midrst_data", 32'(pgm_data), 32'd0);
        check_eq("midrst_done", 32'(load_done), 32'd0);
        check_eq("midrst_err", 32'(load_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_release_ready", 32'(rx_ready), 32'd1);
        $display("[TB] mid-frame reset: outputs at reset values");

        for (int f = 0; f < 25; f++) begin
            int  n;
            bit  bad;
            n = $urandom_range(1, 6);
            tx_words.delete();
            for (int i = 0; i < n; i++) tx_words.push_back(16'($urandom_range(0, 65535)));
            bad = ($urandom_range(0, 3) == 0);
            send_frame($sformatf("rand%0d", f), $urandom_range(0, 3), $urandom_range(0, 12),
                       bad, 1'($urandom_range(0, 1)));
            if (!bad) do_reload();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
